// File: rtl/track_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : track_mode_ctrl
// Brief    : Frame-synchronous auto/manual tracker selector with blanking and
//            lost-target timeout. Optional macro TRACK_AUTOSKIP_EN makes manual
//            stepping skip to the next slot that reports a detection.
// Revision : 1.0 - initial release
// ============================================================================
module track_mode_ctrl #(
    parameter int         NUM_TARGETS  = 16,
    parameter int         LOST_FRAMES  = 30,
    parameter int         BLANK_FRAMES = 2,
    parameter logic [7:0] KEY_AUTO     = 8'h1C,
    parameter logic [7:0] KEY_MANUAL   = 8'h3A,
    parameter logic [7:0] KEY_NEXT     = 8'h74,
    parameter logic [7:0] KEY_PREV     = 8'h6B,
    localparam int        IDX_W        = $clog2(NUM_TARGETS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [7:0]             key_code,
    input  logic                   v_sync,
    input  logic                   aim_detected_auto,
    input  logic [NUM_TARGETS-1:0] aim_detected_all,
    output logic                   mode_sel,
    output logic [IDX_W-1:0]       target_idx,
    output logic                   overlay_en,
    output logic                   target_off,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN_AUTO = 2'b00,
        ST_RUN_MAN  = 2'b01,
        ST_BLANK    = 2'b10,
        ST_UNUSED   = 2'b11
    } state_t;

    localparam logic [7:0] c_lost_max   = 8'(LOST_FRAMES);
    localparam logic [3:0] c_blank_init = 4'(BLANK_FRAMES);

    state_t           r_state;
    logic             r_v_sync_prev;
    logic [3:0]       r_blank_cnt;
    logic [7:0]       r_lost_cnt;
    logic             r_pend_mode_vld;
    logic             r_pend_mode;
    logic             r_pend_step_vld;
    logic             r_pend_step_dir;   // 1 = previous slot

    logic             w_fs;
    logic             w_det;
    logic             w_mode_change;
    logic [7:0]       w_lost_inc;
    logic [IDX_W-1:0] w_step_idx;
    logic             w_step_ok;

    assign w_fs          = r_v_sync_prev & ~v_sync;
    assign w_det         = mode_sel ? aim_detected_all[target_idx] : aim_detected_auto;
    assign w_mode_change = r_pend_mode_vld && (r_pend_mode != mode_sel);
    assign w_lost_inc    = (r_lost_cnt >= c_lost_max) ? c_lost_max : r_lost_cnt + 8'd1;
    assign state_dbg     = r_state;

`ifdef TRACK_AUTOSKIP_EN
    logic [IDX_W-1:0] w_cand;

    // Scan farthest-first so the nearest detected slot is the last one written.
    always_comb begin
        w_step_idx = target_idx;
        w_step_ok  = 1'b0;
        w_cand     = target_idx;
        for (int k = NUM_TARGETS - 1; k >= 1; k--) begin
            w_cand = r_pend_step_dir ? IDX_W'(target_idx - IDX_W'(k))
                                     : IDX_W'(target_idx + IDX_W'(k));
            if (aim_detected_all[w_cand]) begin
                w_step_idx = w_cand;
                w_step_ok  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_step_idx = r_pend_step_dir ? IDX_W'(target_idx - IDX_W'(1))
                                     : IDX_W'(target_idx + IDX_W'(1));
        w_step_ok  = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_BLANK;
            r_v_sync_prev   <= 1'b1;
            r_blank_cnt     <= c_blank_init;
            r_lost_cnt      <= 8'd0;
            r_pend_mode_vld <= 1'b0;
            r_pend_mode     <= 1'b0;
            r_pend_step_vld <= 1'b0;
            r_pend_step_dir <= 1'b0;
            mode_sel        <= 1'b0;
            target_idx      <= '0;
            overlay_en      <= 1'b0;
            target_off      <= 1'b1;
        end else begin
            r_v_sync_prev <= v_sync;

            if (w_fs) begin
                // Every frame start consumes whatever was pending before it.
                r_pend_mode_vld <= 1'b0;
                r_pend_step_vld <= 1'b0;

                case (r_state)
                    ST_RUN_AUTO, ST_RUN_MAN: begin
                        if (w_mode_change) begin
                            r_state     <= ST_BLANK;
                            mode_sel    <= r_pend_mode;
                            r_blank_cnt <= c_blank_init;
                            r_lost_cnt  <= 8'd0;
                            overlay_en  <= 1'b0;
                            target_off  <= 1'b1;
                        end else begin
                            overlay_en <= 1'b1;
                            if (w_det) begin
                                r_lost_cnt <= 8'd0;
                                target_off <= 1'b0;
                            end else begin
                                r_lost_cnt <= w_lost_inc;
                                if (w_lost_inc >= c_lost_max)
                                    target_off <= 1'b1;
                            end
                            if ((r_state == ST_RUN_MAN) && r_pend_step_vld && w_step_ok) begin
                                target_idx <= w_step_idx;
                                r_lost_cnt <= 8'd0;
                            end
                        end
                    end
                    default: begin
                        overlay_en <= 1'b0;
                        target_off <= 1'b1;
                        if (w_mode_change) begin
                            r_state     <= ST_BLANK;
                            mode_sel    <= r_pend_mode;
                            r_blank_cnt <= c_blank_init;
                            r_lost_cnt  <= 8'd0;
                        end else if (r_blank_cnt <= 4'd1) begin
                            r_state     <= mode_sel ? ST_RUN_MAN : ST_RUN_AUTO;
                            r_blank_cnt <= 4'd0;
                            overlay_en  <= 1'b1;
                        end else begin
                            r_state     <= ST_BLANK;
                            r_blank_cnt <= r_blank_cnt - 4'd1;
                        end
                    end
                endcase
            end

            // A key arriving on the frame-start cycle is kept for the next frame.
            if (key_valid) begin
                if (key_code == KEY_AUTO) begin
                    r_pend_mode_vld <= 1'b1;
                    r_pend_mode     <= 1'b0;
                end else if (key_code == KEY_MANUAL) begin
                    r_pend_mode_vld <= 1'b1;
                    r_pend_mode     <= 1'b1;
                end else if (key_code == KEY_NEXT) begin
                    r_pend_step_vld <= 1'b1;
                    r_pend_step_dir <= 1'b0;
                end else if (key_code == KEY_PREV) begin
                    r_pend_step_vld <= 1'b1;
                    r_pend_step_dir <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_track_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_track_mode_ctrl
// Brief    : Scoreboard bench for track_mode_ctrl; expected output snapshots
//            are queued with each frame-start stimulus and compared afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_track_mode_ctrl;

    localparam logic [1:0] c_st_auto  = 2'b00;
    localparam logic [1:0] c_st_man   = 2'b01;
    localparam logic [1:0] c_st_blank = 2'b10;
    localparam logic [7:0] c_k_auto   = 8'h1C;
    localparam logic [7:0] c_k_man    = 8'h3A;
    localparam logic [7:0] c_k_next   = 8'h74;
    localparam logic [7:0] c_k_prev   = 8'h6B;
    localparam logic [7:0] c_k_other  = 8'h55;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        v_sync = 1'b1;
    logic        aim_detected_auto = 1'b1;
    logic [15:0] aim_detected_all = 16'h0000;
    logic        mode_sel;
    logic [3:0]  target_idx;
    logic        overlay_en;
    logic        target_off;
    logic [1:0]  state_dbg;

    typedef struct packed {
        logic       mode;
        logic [3:0] idx;
        logic       ov;
        logic       off;
        logic [1:0] st;
    } obs_t;

    obs_t sb[$];
    obs_t e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    track_mode_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .key_valid         (key_valid),
        .key_code          (key_code),
        .v_sync            (v_sync),
        .aim_detected_auto (aim_detected_auto),
        .aim_detected_all  (aim_detected_all),
        .mode_sel          (mode_sel),
        .target_idx        (target_idx),
        .overlay_en        (overlay_en),
        .target_off        (target_off),
        .state_dbg         (state_dbg)
    );

    function automatic obs_t mk(input logic m, input logic [3:0] i, input logic o,
                                input logic f, input logic [1:0] s);
        obs_t r;
        r.mode = m; r.idx = i; r.ov = o; r.off = f; r.st = s;
        return r;
    endfunction

    function automatic obs_t cur();
        obs_t r;
        r.mode = mode_sel; r.idx = target_idx; r.ov = overlay_en;
        r.off = target_off; r.st = state_dbg;
        return r;
    endfunction

    // Returns one time unit after the clock edge that sees the frame start.
    task automatic pulse_fs();
        @(negedge clk); v_sync = 1'b1;
        @(negedge clk); v_sync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_fs_key(input logic [7:0] code);
        @(negedge clk); v_sync = 1'b1;
        @(negedge clk); v_sync = 1'b0; key_valid = 1'b1; key_code = code;
        @(posedge clk); #1;
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clk); key_valid = 1'b1; key_code = code;
        @(negedge clk); key_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, c_st_blank));
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL reset_state: got=%b want=%b", cur(), e);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_blank_to_auto(input string name);
        aim_detected_auto = 1'b1;
        sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, c_st_auto));
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, c_st_auto));
        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL %s fs%0d: got=%b want=%b", name, i + 1, cur(), e);
            end
        end
    endtask

    task automatic test_switch_manual();
        send_key(c_k_man);
        repeat (2) @(negedge clk);
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, c_st_auto));
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL switch_hold_until_fs: got=%b want=%b", cur(), e);
        end
        aim_detected_all = 16'hFFFF;
        sb.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b1, 4'd0, 1'b1, 1'b1, c_st_man));
        sb.push_back(mk(1'b1, 4'd0, 1'b1, 1'b0, c_st_man));
        for (int i = 0; i < 4; i++) begin
            if (i == 1) send_key(c_k_next);
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL switch_manual fs%0d: got=%b want=%b", i + 1, cur(), e);
            end
        end
    endtask

    task automatic test_step_wrap();
        logic [7:0] k1 [6];
        logic [7:0] k2 [6];
        logic [3:0] ix [6];
        k1 = '{c_k_prev, c_k_next, c_k_prev, c_k_next, c_k_next,  c_k_prev};
        k2 = '{8'h00,    8'h00,    c_k_prev, c_k_prev, c_k_other, c_k_other};
        ix = '{4'd15,    4'd0,     4'd15,    4'd14,    4'd15,     4'd14};
        for (int i = 0; i < 6; i++) begin
            send_key(k1[i]);
            send_key(k2[i]);
            sb.push_back(mk(1'b1, ix[i], 1'b1, 1'b0, c_st_man));
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL step_wrap row%0d: got=%b want=%b", i, cur(), e);
            end
        end
    endtask

    task automatic test_lost();
        aim_detected_all = ~(16'h0001 << 14);
        for (int i = 1; i <= 30; i++) begin
            sb.push_back(mk(1'b1, 4'd14, 1'b1, (i == 30), c_st_man));
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL lost_count f%0d: got=%b want=%b", i, cur(), e);
            end
        end
        aim_detected_all = 16'h0001 << 14;
        sb.push_back(mk(1'b1, 4'd14, 1'b1, 1'b0, c_st_man));
        pulse_fs();
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL lost_recover: got=%b want=%b", cur(), e);
        end
        aim_detected_all = 16'h0000;
        for (int i = 1; i <= 29; i++) begin
            sb.push_back(mk(1'b1, 4'd14, 1'b1, 1'b0, c_st_man));
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL lost_cnt_cleared f%0d: got=%b want=%b", i, cur(), e);
            end
        end
        aim_detected_all = 16'hFFFF;
    endtask

    task automatic test_key_on_fs_and_reset();
        sb.push_back(mk(1'b1, 4'd14, 1'b1, 1'b0, c_st_man));
        sb.push_back(mk(1'b0, 4'd14, 1'b0, 1'b1, c_st_blank));
        pulse_fs_key(c_k_auto);
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL key_on_fs_no_switch: got=%b want=%b", cur(), e);
        end
        @(negedge clk); key_valid = 1'b0;
        pulse_fs();
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL key_on_fs_next_switch: got=%b want=%b", cur(), e);
        end
        @(negedge clk); v_sync = 1'b1;
        #2 reset = 1'b1;
        #1;
        sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, c_st_blank));
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL async_reset_in_blank: got=%b want=%b", cur(), e);
        end
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_same_mode_discard();
        send_key(c_k_auto);
        send_key(c_k_next);
        send_key(c_k_other);
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, c_st_auto));
        pulse_fs();
        e = sb.pop_front(); total++;
        if (cur() !== e) begin
            bad++; $display("FAIL same_mode_discard: got=%b want=%b", cur(), e);
        end
    endtask

    task automatic test_blank_restart();
        sb.push_back(mk(1'b1, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, c_st_blank));
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, c_st_auto));
        sb.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, c_st_auto));
        for (int i = 0; i < 5; i++) begin
            if (i == 0) send_key(c_k_man);
            if (i == 1) send_key(c_k_auto);
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL blank_restart fs%0d: got=%b want=%b", i + 1, cur(), e);
            end
        end
    endtask

`ifdef TRACK_AUTOSKIP_EN
    task automatic test_autoskip();
        logic [15:0] msk [6];
        obs_t        ex  [6];
        msk = '{16'h0000, 16'h0000, 16'h0000, 16'h0204, 16'h0204, 16'h0200};
        ex[0] = mk(1'b1, 4'd0, 1'b0, 1'b1, c_st_blank);
        ex[1] = mk(1'b1, 4'd0, 1'b0, 1'b1, c_st_blank);
        ex[2] = mk(1'b1, 4'd0, 1'b1, 1'b1, c_st_man);
        ex[3] = mk(1'b1, 4'd2, 1'b1, 1'b1, c_st_man);
        ex[4] = mk(1'b1, 4'd9, 1'b1, 1'b0, c_st_man);
        ex[5] = mk(1'b1, 4'd9, 1'b1, 1'b0, c_st_man);
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            aim_detected_all = msk[i];
            if (i == 0) send_key(c_k_man);
            if (i >= 3) send_key(c_k_next);
            pulse_fs();
            e = sb.pop_front(); total++;
            if (cur() !== e) begin
                bad++; $display("FAIL autoskip fs%0d: got=%b want=%b", i + 1, cur(), e);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_blank_to_auto("blank_to_auto");
        test_switch_manual();
        test_step_wrap();
        test_lost();
        test_key_on_fs_and_reset();
        test_blank_to_auto("blank_after_reset");
        test_same_mode_discard();
        test_blank_restart();
`ifdef TRACK_AUTOSKIP_EN
        test_autoskip();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
